// File: rtl/um_operand_fetch.sv
// um_operand_fetch: read-side sequencer for the 8x32 UM register bank.
// Accepts one instruction, walks the bank's read port through the operand
// registers that opcode needs (A, then B, then C, one per granted cycle),
// and presents the decoded bundle to execute through a valid/ready handshake.
module um_operand_fetch #(
  parameter int         DATA_W   = 32,
  parameter logic [2:0] IDLE_SEL = 3'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  output logic [2:0]        reg_select,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              reg_grant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_opcode,
  output logic [2:0]        out_a_idx,
  output logic [DATA_W-1:0] out_val_a,
  output logic [DATA_W-1:0] out_val_b,
  output logic [DATA_W-1:0] out_val_c,
  output logic [24:0]       out_imm,
  output logic              out_illegal
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_RD_C = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [3:0] OP_ORTHO = 4'd13;

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic [2:0] b_idx_reg;
  logic [2:0] c_idx_reg;
  logic [2:0] need;

  // Operands an opcode reads, as a {A, B, C} mask.
  function automatic logic [2:0] read_set(input logic [3:0] op);
    logic [2:0] m;
    case (op)
      4'd2:                                  m = 3'b111;
      4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6,
      4'd12:                                 m = 3'b011;
      4'd8, 4'd9, 4'd10:                     m = 3'b001;
      default:                               m = 3'b000;
    endcase
    return m;
  endfunction

  // First read state still outstanding in a {A, B, C} mask, else DONE.
  function automatic logic [2:0] first_state(input logic [2:0] m);
    logic [2:0] s;
    if (m[2])      s = S_RD_A;
    else if (m[1]) s = S_RD_B;
    else if (m[0]) s = S_RD_C;
    else           s = S_DONE;
    return s;
  endfunction

  // The latched opcode selects the remaining reads while sequencing.
  assign need      = read_set(out_opcode);
  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);

  // Next-state: advance through the required reads only on granted cycles.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (in_valid)  state_next = first_state(read_set(in_instr[31:28]));
      S_RD_A: if (reg_grant) state_next = first_state(need & 3'b011);
      S_RD_B: if (reg_grant) state_next = first_state(need & 3'b001);
      S_RD_C: if (reg_grant) state_next = S_DONE;
      S_DONE: if (out_ready) state_next = S_IDLE;
      default:               state_next = S_IDLE;
    endcase
  end

  // Bank select follows the state directly; idle value whenever not reading.
  always_comb begin
    reg_select = IDLE_SEL;
    case (state_reg)
      S_RD_A:  reg_select = out_a_idx;
      S_RD_B:  reg_select = b_idx_reg;
      S_RD_C:  reg_select = c_idx_reg;
      default: reg_select = IDLE_SEL;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Decode on accept, capture operands on granted read cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_opcode  <= 4'd0;
      out_a_idx   <= 3'd0;
      b_idx_reg   <= 3'd0;
      c_idx_reg   <= 3'd0;
      out_val_a   <= '0;
      out_val_b   <= '0;
      out_val_c   <= '0;
      out_imm     <= 25'd0;
      out_illegal <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && in_valid) begin
        out_opcode  <= in_instr[31:28];
        // Orthography (load value) carries its A index beside the immediate.
        out_a_idx   <= (in_instr[31:28] == OP_ORTHO) ? in_instr[27:25] : in_instr[8:6];
        b_idx_reg   <= in_instr[5:3];
        c_idx_reg   <= in_instr[2:0];
        out_imm     <= (in_instr[31:28] == OP_ORTHO) ? in_instr[24:0] : 25'd0;
        out_illegal <= (in_instr[31:28] >= 4'd14);
        out_val_a   <= '0;
        out_val_b   <= '0;
        out_val_c   <= '0;
      end
      if (reg_grant) begin
        case (state_reg)
          S_RD_A:  out_val_a <= reg_data;
          S_RD_B:  out_val_b <= reg_data;
          S_RD_C:  out_val_c <= reg_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_um_operand_fetch.sv
// Bench for um_operand_fetch: a bank model answers reg_select, a reference
// model predicts each bundle at issue time, and a separate monitor checks
// the read sequence and the bundle when the DUT presents it.
module tb_um_operand_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = 32'd0;
  logic [2:0]  reg_select;
  logic [31:0] reg_data;
  logic        reg_grant = 1'b1;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_opcode;
  logic [2:0]  out_a_idx;
  logic [31:0] out_val_a, out_val_b, out_val_c;
  logic [24:0] out_imm;
  logic        out_illegal;

  um_operand_fetch #(.DATA_W(32), .IDLE_SEL(3'd0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .reg_select(reg_select), .reg_data(reg_data), .reg_grant(reg_grant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_a_idx(out_a_idx),
    .out_val_a(out_val_a), .out_val_b(out_val_b), .out_val_c(out_val_c),
    .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // Register bank model: combinational read.
  logic [31:0] bank [8];
  assign reg_data = bank[reg_select];

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  a;
    logic [31:0] va, vb, vc;
    logic [24:0] imm;
    logic        ill;
    int          n;
    logic [2:0]  sel [3];
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   issued = 0;
  int   done_cnt = 0;
  bit   rand_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: which registers an opcode reads, in A,B,C order, and their contents.
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    logic [2:0] ra, rb, rc;
    bit ua, ub, uc;
    ra = ins[8:6]; rb = ins[5:3]; rc = ins[2:0];
    e.op  = ins[31:28];
    ua = (e.op == 4'd2);
    ub = (e.op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd12});
    uc = ub || (e.op inside {4'd8, 4'd9, 4'd10});
    e.a   = (e.op == 4'd13) ? ins[27:25] : ra;
    e.imm = (e.op == 4'd13) ? ins[24:0] : 25'd0;
    e.ill = (e.op == 4'd14) || (e.op == 4'd15);
    e.va = 32'd0; e.vb = 32'd0; e.vc = 32'd0;
    e.n = 0;
    e.sel[0] = 3'd0; e.sel[1] = 3'd0; e.sel[2] = 3'd0;
    if (ua) begin e.sel[e.n] = ra; e.n++; e.va = bank[ra]; end
    if (ub) begin e.sel[e.n] = rb; e.n++; e.vb = bank[rb]; end
    if (uc) begin e.sel[e.n] = rc; e.n++; e.vc = bank[rc]; end
    return e;
  endfunction

  // Monitor: tracks each accepted instruction, the selects on granted cycles,
  // and compares the bundle when the handshake completes.
  initial begin
    bit act = 1'b0;
    bit seen = 1'b0;
    int cnt = 0;
    logic [2:0] s [3];
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        act = 1'b0;
      end else if (act) begin
        if (out_valid) begin
          if (!seen) begin
            seen = 1'b1;
            check("read_count", cnt, e.n);
            for (int i = 0; i < e.n && i < cnt && i < 3; i++)
              check($sformatf("select%0d", i), {29'd0, s[i]}, {29'd0, e.sel[i]});
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            check("select_done", {29'd0, reg_select}, 32'd0);
          end
          if (out_ready) begin
            $display("txn op=%0d a=%0d va=%h vb=%h vc=%h imm=%h ill=%0d",
                     out_opcode, out_a_idx, out_val_a, out_val_b, out_val_c, out_imm, out_illegal);
            check("opcode", {28'd0, out_opcode}, {28'd0, e.op});
            check("a_idx", {29'd0, out_a_idx}, {29'd0, e.a});
            check("val_a", out_val_a, e.va);
            check("val_b", out_val_b, e.vb);
            check("val_c", out_val_c, e.vc);
            check("imm", {7'd0, out_imm}, {7'd0, e.imm});
            check("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
            act = 1'b0;
            done_cnt++;
          end
        end else if (reg_grant) begin
          if (cnt < 3) s[cnt] = reg_select;
          cnt++;
        end
      end else if (in_valid && in_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL scoreboard: accept seen with no expected entry");
        end else begin
          e = sb.pop_front();
          act = 1'b1; seen = 1'b0; cnt = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) begin
      reg_grant = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    int k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout: in_ready got 0 required 1");
    end
    in_instr = ins;
    in_valid = 1'b1;
    sb.push_back(model(ins));
    issued++;
    tick();
    in_valid = 1'b0;
    in_instr = $urandom;
  endtask

  task automatic drain();
    int k = 0;
    while (done_cnt < issued && k < 200) begin tick(); k++; end
    if (done_cnt < issued) begin
      total++; bad++;
      $display("FAIL drain_timeout: done %0d required %0d", done_cnt, issued);
      done_cnt = issued;
    end
  endtask

  // Issue with grant high and out_ready low; measure edges from accept to out_valid.
  task automatic lat(input logic [31:0] ins, input int exp_edges);
    int k;
    out_ready = 1'b0;
    issue(ins);
    k = 1;
    while (!out_valid && k < 50) begin tick(); k++; end
    check($sformatf("latency_%h", ins), k, exp_edges);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_valid", {31'd0, out_valid}, 32'd0);
    drain();
  endtask

  initial begin
    exp_t eh;
    int k;
    logic [31:0] ins;
    for (int i = 0; i < 8; i++) bank[i] = i * 32'h11111111;

    // Reset state
    reset = 1'b0;
    tick(); tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_select", {29'd0, reg_select}, 32'd0);
    check("rst_val_a", out_val_a, 32'd0);
    check("rst_val_c", out_val_c, 32'd0);
    check("rst_imm", {7'd0, out_imm}, 32'd0);
    reset = 1'b1;
    tick();

    // Directed latencies across read-set classes
    reg_grant = 1'b1;
    lat(32'h30000053, 3);
    lat(32'h20000177, 4);
    lat(32'hD81ABCDE, 1);
    lat(32'hE0000000, 1);
    lat(32'hF00001FF, 1);
    lat(32'h70000000, 1);
    lat(32'h8000003A, 2);

    // Grant withheld for two cycles during the C read
    out_ready = 1'b0;
    issue(32'h30000053);
    tick();
    check("stall_sel_c", {29'd0, reg_select}, 32'd3);
    reg_grant = 1'b0;
    tick();
    check("stall_sel_hold1", {29'd0, reg_select}, 32'd3);
    check("stall_valid1", {31'd0, out_valid}, 32'd0);
    tick();
    check("stall_sel_hold2", {29'd0, reg_select}, 32'd3);
    check("stall_valid2", {31'd0, out_valid}, 32'd0);
    reg_grant = 1'b1;
    tick();
    check("stall_valid_after", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    drain();

    // Hold out_ready low in DONE; a new in_valid must be ignored
    issue(32'h20000177);
    eh = model(32'h20000177);
    k = 0;
    while (!out_valid && k < 20) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h3000_0000 | ($urandom & 32'h1FF);
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_val_c", out_val_c, eh.vc);
      check("hold_opcode", {28'd0, out_opcode}, {28'd0, eh.op});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_ready", {31'd0, in_ready}, 32'd1);
    check("hold_release_valid", {31'd0, out_valid}, 32'd0);
    drain();

    // Reset while reading B discards the instruction
    issue(32'h30000053);
    check("pre_reset_sel_b", {29'd0, reg_select}, 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    sb.delete();
    done_cnt = issued;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_select", {29'd0, reg_select}, 32'd0);
    check("mid_rst_val_b", out_val_b, 32'd0);
    lat(32'hA0000002, 2);

    // Randomized traffic with random grant and out_ready
    rand_mode = 1'b1;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < 8; i++) bank[i] = $urandom;
      ins = $urandom;
      if (t % 3 == 0) ins[31:28] = 4'd2;
      issue(ins);
      drain();
    end
    rand_mode = 1'b0;
    reg_grant = 1'b1;
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/um_operand_fetch.md
Name: um_operand_fetch

Overview:
Read-side sequencer for the 8x32 UM register bank. It accepts one 32-bit UM instruction word, decodes its register fields, and drives the bank's reg_select to read the required operands one per cycle. The bank's out is combinational on reg_select. The block then presents the captured operands and decoded fields to execute through a valid/ready handshake. It sits between instruction fetch and the ALU/array units. It shares the bank's select lines with the writeback path through a grant input.

Parameters:
DATA_W, 32, register/instruction width; only 32 is supported by the decode.
IDLE_SEL, 3'd0, value driven on reg_select when no read is in progress.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  synchronous, active-low reset.
in_valid  input  1  in_instr is valid.
in_ready  output  1  block can accept an instruction.
in_instr  input  32  UM instruction word.
reg_select  output  3  register index to the bank.
reg_data  input  32  bank out for reg_select, combinational.
reg_grant  input  1  bank read port is granted this cycle.
out_valid  output  1  decoded bundle is valid.
out_ready  input  1  consumer accepts the bundle.
out_opcode  output  4  in_instr[31:28].
out_a_idx  output  3  A index: [8:6], or [27:25] for opcode 13.
out_val_a  output  32  contents of register A (0 if not read).
out_val_b  output  32  contents of register B (0 if not read).
out_val_c  output  32  contents of register C (0 if not read).
out_imm  output  25  in_instr[24:0] for opcode 13, else 0.
out_illegal  output  1  opcode 14 or 15.

Behaviour:
- Reset (reset==0 at an edge): state IDLE; in_ready=1; out_valid=0; reg_select=IDLE_SEL; all out_* registers=0. Reset overrides any in-flight instruction; partial captures are discarded.
- Read set per opcode:
  - 0, 1, 3, 4, 5, 6, 12: read B, C.
  - 2: read A, B, C.
  - 8, 9, 10: read C.
  - 7, 11, 13, 14, 15: no reads.
- States: IDLE, RD_A, RD_B, RD_C, DONE.
- IDLE: in_ready=1. On in_valid at an edge:
  - latch the instruction;
  - clear out_val_a, out_val_b and out_val_c;
  - go to the first required RD state in order A, B, C, or to DONE if none are required.
- RD_x: reg_select = that field's index, combinationally from state.
  - reg_grant=1 at the edge: capture reg_data into out_val_x, then advance to the next required RD state or DONE.
  - reg_grant=0: hold state; no capture.
- DONE: out_valid=1; outputs stable. out_ready=1 at an edge returns to IDLE. Back-to-back acceptance is not supported; in_ready=0 outside IDLE.
- Latency with grant held high: out_valid rises N+1 edges after the accept edge, where N is the number of reads. Zero-read opcodes assert out_valid after the accept edge.
- reg_select=IDLE_SEL in IDLE and DONE.
- Opcodes 14 and 15 set out_illegal=1 and do no reads; the handshake is otherwise normal.
- For opcode 13, B and C are not decoded, and out_imm is zero-extended 25 bits.
- in_instr is ignored outside IDLE.

Test Plan:
- Preload bank reg i = i*0x11111111, grant=1. Send 0x30000053 (add A=1, B=2, C=3) -> reg_select goes 2 then 3 on consecutive cycles; out_valid 3 edges after accept; opcode=3, a_idx=1, val_a=0, val_b=0x22222222, val_c=0x33333333.
- Same bank. Send 0x20000177 (amend A=5, B=6, C=7) -> selects 5, 6, 7; val_a=0x55555555, val_b=0x66666666, val_c=0x77777777; out_valid 4 edges after accept.
- Send 0xD81ABCDE -> no select activity; out_valid 1 edge after accept; opcode=13, a_idx=4, imm=0x01ABCDE, vals=0. Then send 0xE0000000 -> out_illegal=1, out_valid after 1 edge.
- Send 0x30000053 with reg_grant low for 2 cycles during RD_C -> reg_select holds 3; out_valid delayed exactly 2 cycles; val_c still 0x33333333.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> IDLE next cycle.
- Assert reset=0 while in RD_B -> next edge: IDLE, out_valid=0, vals=0, reg_select=0. A subsequent 0xA0000002 (output, C=2) -> val_c=0x22222222 after 2 edges.
